// File: rtl/cube_color_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : cube_color_ctrl_if
// Description : Landing-event channel from the player-move logic into the
//               cube colour controller (valid/ready handshake).
// Revision    : 1.0 - initial release
// ============================================================================
interface cube_color_ctrl_if #(
   parameter int N_CUBE = 5
);
   localparam int IDX_W = $clog2(N_CUBE + 1);

   logic             land_valid;
   logic [IDX_W-1:0] land_idx;
   logic             land_ready;

   // Player-move side: issues landing events
   modport master (
      output land_valid,
      output land_idx,
      input  land_ready
   );

   // Controller side: accepts landing events
   modport slave (
      input  land_valid,
      input  land_idx,
      output land_ready
   );
endinterface
`default_nettype wire

// File: rtl/cube_color_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cube_color_ctrl
// Description : Level-progress controller for the cube pyramid. Owns the
//               top-colour mask and done_move enable, marks landed cubes,
//               detects level completion, blinks all faces on a frame-timed
//               schedule and then holds level_done until the next level.
// Options     : CUBE_TOGGLE_EN - landing on an already-coloured cube clears
//               it again instead of leaving it set.
// Revision    : 1.0 - initial release
// ============================================================================
module cube_color_ctrl #(
   parameter  int N_CUBE       = 5,
   parameter  int BLINK_PERIOD = 8,
   parameter  int BLINK_COUNT  = 6,
   localparam int IDX_W        = $clog2(N_CUBE + 1)
) (
   input  wire logic          clk,
   input  wire logic          reset,
   input  wire logic          frame_tick,
   input  wire logic          level_start,
   cube_color_ctrl_if.slave   land,
   output logic [N_CUBE:0]    top_color_mask,
   output logic               done_move,
   output logic [IDX_W:0]     colored_cnt,
   output logic               level_done,
   output logic               bad_idx
);

   localparam int MASK_W  = N_CUBE + 1;
   localparam int CNT_W   = IDX_W + 1;
   localparam int FRAME_W = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;
   localparam int HALF_W  = (BLINK_COUNT > 1) ? $clog2(BLINK_COUNT + 1) : 1;

   localparam logic [FRAME_W-1:0] c_frame_last = FRAME_W'(BLINK_PERIOD - 1);
   localparam logic [HALF_W-1:0]  c_half_last  = HALF_W'(BLINK_COUNT - 1);
   localparam logic [IDX_W-1:0]   c_idx_max    = IDX_W'(N_CUBE);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_PLAY  = 3'd1,
      ST_CHECK = 3'd2,
      ST_WIN   = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   state_t              r_state,      w_state_nxt;
   logic [MASK_W-1:0]   r_mask,       w_mask_nxt;
   logic [CNT_W-1:0]    r_cnt,        w_cnt_nxt;
   logic                r_done_move,  w_done_move_nxt;
   logic                r_level_done, w_level_done_nxt;
   logic                r_bad,        w_bad_nxt;
   logic [FRAME_W-1:0]  r_frame,      w_frame_nxt;
   logic [HALF_W-1:0]   r_half,       w_half_nxt;
   logic                r_phase,      w_phase_nxt;

   logic                w_land_ready;
   logic                w_idx_ok;
   logic [MASK_W-1:0]   w_onehot;
   logic [CNT_W-1:0]    w_popcnt;

   assign w_land_ready    = (r_state == ST_PLAY);
   assign w_idx_ok        = (land.land_idx <= c_idx_max);
   assign w_onehot        = MASK_W'(1) << land.land_idx;

   assign land.land_ready = w_land_ready;
   assign top_color_mask  = r_mask;
   assign done_move       = r_done_move;
   assign colored_cnt     = r_cnt;
   assign level_done      = r_level_done;
   assign bad_idx         = r_bad;

   // Number of cubes currently showing the target colour
   always_comb begin
      w_popcnt = '0;
      for (int i = 0; i < MASK_W; i++) begin
         w_popcnt = w_popcnt + CNT_W'(r_mask[i]);
      end
   end

   // Next-state and next-output decode; level_start overrides everything
   always_comb begin
      w_state_nxt      = r_state;
      w_mask_nxt       = r_mask;
      w_cnt_nxt        = r_cnt;
      w_done_move_nxt  = r_done_move;
      w_level_done_nxt = r_level_done;
      w_bad_nxt        = r_bad;
      w_frame_nxt      = r_frame;
      w_half_nxt       = r_half;
      w_phase_nxt      = r_phase;

      if (level_start) begin
         w_state_nxt      = ST_PLAY;
         w_mask_nxt       = '0;
         w_cnt_nxt        = '0;
         w_done_move_nxt  = 1'b1;
         w_level_done_nxt = 1'b0;
         w_bad_nxt        = 1'b0;
         w_frame_nxt      = '0;
         w_half_nxt       = '0;
         w_phase_nxt      = 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_done_move_nxt = 1'b0;
            end
            ST_PLAY: begin
               if (land.land_valid && w_land_ready) begin
                  if (w_idx_ok) begin
`ifdef CUBE_TOGGLE_EN
                     w_mask_nxt = r_mask ^ w_onehot;
`else
                     w_mask_nxt = r_mask | w_onehot;
`endif
                     w_state_nxt = ST_CHECK;
                  end else begin
                     w_bad_nxt = 1'b1;
                  end
               end
            end
            ST_CHECK: begin
               w_cnt_nxt = w_popcnt;
               if (&r_mask) begin
                  // Blink starts on the base colour (phase 0)
                  w_state_nxt     = ST_WIN;
                  w_frame_nxt     = '0;
                  w_half_nxt      = '0;
                  w_phase_nxt     = 1'b0;
                  w_done_move_nxt = 1'b0;
               end else begin
                  w_state_nxt = ST_PLAY;
               end
            end
            ST_WIN: begin
               w_done_move_nxt = r_phase;
               if (frame_tick) begin
                  if (r_frame == c_frame_last) begin
                     w_frame_nxt     = '0;
                     w_phase_nxt     = ~r_phase;
                     w_half_nxt      = r_half + HALF_W'(1);
                     w_done_move_nxt = ~r_phase;
                     if (r_half == c_half_last) begin
                        w_state_nxt      = ST_DONE;
                        w_done_move_nxt  = 1'b1;
                        w_level_done_nxt = 1'b1;
                     end
                  end else begin
                     w_frame_nxt = r_frame + FRAME_W'(1);
                  end
               end
            end
            ST_DONE: begin
               w_done_move_nxt  = 1'b1;
               w_level_done_nxt = 1'b1;
            end
            default: begin
               w_state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   // State and registered outputs; reset wipes any partial update at once
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_mask       <= '0;
         r_cnt        <= '0;
         r_done_move  <= 1'b0;
         r_level_done <= 1'b0;
         r_bad        <= 1'b0;
         r_frame      <= '0;
         r_half       <= '0;
         r_phase      <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_mask       <= w_mask_nxt;
         r_cnt        <= w_cnt_nxt;
         r_done_move  <= w_done_move_nxt;
         r_level_done <= w_level_done_nxt;
         r_bad        <= w_bad_nxt;
         r_frame      <= w_frame_nxt;
         r_half       <= w_half_nxt;
         r_phase      <= w_phase_nxt;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_cube_color_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cube_color_ctrl
// Description : Scoreboard bench for cube_color_ctrl with a queue-based
//               reference model of the cube pyramid and blink schedule.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cube_color_ctrl;

   localparam int N_CUBE = 5;
   localparam int BP     = 2;
   localparam int BC     = 4;
   localparam int IDX_W  = $clog2(N_CUBE + 1);
   localparam int NB     = N_CUBE + 1;

   logic              clk = 1'b0;
   logic              reset;
   logic              frame_tick;
   logic              level_start;
   logic [N_CUBE:0]   top_color_mask;
   logic              done_move;
   logic [IDX_W:0]    colored_cnt;
   logic              level_done;
   logic              bad_idx;

   cube_color_ctrl_if #(.N_CUBE(N_CUBE)) land_if ();

   cube_color_ctrl #(
      .N_CUBE       (N_CUBE),
      .BLINK_PERIOD (BP),
      .BLINK_COUNT  (BC)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .frame_tick     (frame_tick),
      .level_start    (level_start),
      .land           (land_if),
      .top_color_mask (top_color_mask),
      .done_move      (done_move),
      .colored_cnt    (colored_cnt),
      .level_done     (level_done),
      .bad_idx        (bad_idx)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [N_CUBE:0] mask;
      int              cnt;
      logic            bad;
      logic            rdy1;
      logic            rdy2;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad_n = 0;

   // Reference model: which cubes are coloured, and the sticky error flag
   bit   model_on[NB];
   bit   model_bad;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad_n++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic logic [N_CUBE:0] model_pack();
      logic [N_CUBE:0] m;
      m = '0;
      for (int i = 0; i < NB; i++) m[i] = model_on[i];
      return m;
   endfunction

   function automatic int model_count();
      int c;
      c = 0;
      foreach (model_on[i]) if (model_on[i]) c++;
      return c;
   endfunction

   function automatic bit model_full();
      return model_count() == NB;
   endfunction

   function automatic void model_clear();
      foreach (model_on[i]) model_on[i] = 1'b0;
      model_bad = 1'b0;
   endfunction

   // done_move after k frame ticks in WIN: alternates every BP ticks, 1 once finished
   function automatic logic exp_dm(input int k);
      if (k >= BP * BC) return 1'b1;
      return logic'((k / BP) % 2);
   endfunction

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic do_level_start();
      level_start = 1'b1;
      step();
      level_start = 1'b0;
      model_clear();
   endtask

   task automatic land(input int idx, input int gap);
      exp_t e;
      bit   full;
      land_if.land_idx   = IDX_W'(idx);
      land_if.land_valid = 1'b1;
      if (idx <= N_CUBE) begin
`ifdef CUBE_TOGGLE_EN
         model_on[idx] = !model_on[idx];
`else
         model_on[idx] = 1'b1;
`endif
      end else begin
         model_bad = 1'b1;
      end
      full   = model_full();
      e.mask = model_pack();
      e.cnt  = model_count();
      e.bad  = model_bad;
      e.rdy1 = (idx > N_CUBE);
      e.rdy2 = !((idx <= N_CUBE) && full);
      exp_q.push_back(e);
      step();
      land_if.land_valid = 1'b0;
      repeat (gap) begin
         frame_tick = !full && ($urandom_range(0, 3) == 0);
         step();
      end
      frame_tick = 1'b0;
   endtask

   task automatic blink_and_done();
      int nt;
      nt = BP * BC;
      check("win_mask", top_color_mask, {NB{1'b1}});
      check("win_ready", land_if.land_ready, 1'b0);
      check("win_done_move", done_move, 1'b0);
      check("win_level_done", level_done, 1'b0);
      for (int k = 1; k <= nt; k++) begin
         repeat ($urandom_range(0, 2)) begin
            step();
            check("blink_hold", done_move, exp_dm(k - 1));
         end
         frame_tick = 1'b1;
         step();
         frame_tick = 1'b0;
         check("blink_done_move", done_move, exp_dm(k));
         check("blink_level_done", level_done, k >= nt);
      end
      check("done_ready", land_if.land_ready, 1'b0);
   endtask

   task automatic random_level();
      int q[$];
      int idx;
      do_level_start();
      for (int n = 0; n < 60 && !model_full(); n++) begin
         q.delete();
         foreach (model_on[i]) if (!model_on[i]) q.push_back(i);
         if ($urandom_range(0, 9) < 7 && q.size() > 0)
            idx = q[$urandom_range(0, q.size() - 1)];
         else
            idx = $urandom_range(0, 7);
         land(idx, $urandom_range(2, 4));
      end
      if (model_full()) begin
         blink_and_done();
      end else begin
         do_level_start();
         check("abort_mask", top_color_mask, '0);
         check("abort_ready", land_if.land_ready, 1'b1);
      end
   endtask

   // Monitor: every accepted landing pops one expected response
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (land_if.land_valid && land_if.land_ready && !level_start && !reset) begin
            if (exp_q.size() == 0) begin
               total++;
               bad_n++;
               $display("FAIL sb_empty: accept seen with no expected entry at %0t", $time);
            end else begin
               e = exp_q.pop_front();
               @(posedge clk);
               #1;
               check("sb_ready_after_accept", land_if.land_ready, e.rdy1);
               check("sb_mask", top_color_mask, e.mask);
               @(posedge clk);
               #1;
               check("sb_cnt", colored_cnt, e.cnt);
               check("sb_bad", bad_idx, e.bad);
               check("sb_ready_next", land_if.land_ready, e.rdy2);
            end
         end
      end
   end

   initial begin
      reset              = 1'b1;
      frame_tick         = 1'b0;
      level_start        = 1'b0;
      land_if.land_valid = 1'b0;
      land_if.land_idx   = '0;
      model_clear();
      repeat (3) @(posedge clk);
      #2;
      check("rst_mask", top_color_mask, '0);
      check("rst_done_move", done_move, 1'b0);
      check("rst_cnt", colored_cnt, '0);
      check("rst_level_done", level_done, 1'b0);
      check("rst_bad", bad_idx, 1'b0);
      check("rst_ready", land_if.land_ready, 1'b0);
      reset = 1'b0;
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      check("idle_ready", land_if.land_ready, 1'b0);
      check("idle_done_move", done_move, 1'b0);

      do_level_start();
      check("start_ready", land_if.land_ready, 1'b1);
      check("start_done_move", done_move, 1'b1);
      check("start_mask", top_color_mask, '0);
      check("start_level_done", level_done, 1'b0);

      land(0, 2);
      land(2, 2);
      land(4, 2);
      check("even_mask", top_color_mask, 6'b010101);
      check("even_cnt", colored_cnt, 3);

      do_level_start();
      for (int i = 0; i <= N_CUBE; i++) land(i, 2);
      blink_and_done();
      check("done_level_done", level_done, 1'b1);
      check("done_done_move", done_move, 1'b1);

      do_level_start();
      check("restart_level_done", level_done, 1'b0);
      check("restart_mask", top_color_mask, '0);
      check("restart_cnt", colored_cnt, '0);
      land(7, 2);
      check("bad_set", bad_idx, 1'b1);
      check("bad_mask", top_color_mask, '0);
      land(3, 2);
      check("bad_sticky", bad_idx, 1'b1);
      do_level_start();
      check("bad_cleared", bad_idx, 1'b0);

      land(2, 2);
      check("twice_first_bit", top_color_mask[2], 1'b1);
      check("twice_first_cnt", colored_cnt, 1);
      land(2, 2);
`ifdef CUBE_TOGGLE_EN
      check("twice_second_bit", top_color_mask[2], 1'b0);
      check("twice_second_cnt", colored_cnt, 0);
`else
      check("twice_second_bit", top_color_mask[2], 1'b1);
      check("twice_second_cnt", colored_cnt, 1);
`endif

      land(1, 2);
      land_if.land_idx   = IDX_W'(3);
      land_if.land_valid = 1'b1;
      level_start        = 1'b1;
      step();
      land_if.land_valid = 1'b0;
      level_start        = 1'b0;
      model_clear();
      check("collide_mask", top_color_mask, '0);
      check("collide_ready", land_if.land_ready, 1'b1);
      step();
      check("collide_stay_play", land_if.land_ready, 1'b1);
      check("collide_mask_later", top_color_mask, '0);

      for (int l = 0; l < 4; l++) random_level();

      do_level_start();
      for (int i = 0; i <= N_CUBE; i++) land(i, 2);
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      reset = 1'b1;
      #1;
      check("winrst_mask", top_color_mask, '0);
      check("winrst_done_move", done_move, 1'b0);
      check("winrst_level_done", level_done, 1'b0);
      check("winrst_ready", land_if.land_ready, 1'b0);
      step();
      reset = 1'b0;
      model_clear();
      step();
      check("winrst_idle_ready", land_if.land_ready, 1'b0);
      check("winrst_idle_cnt", colored_cnt, '0);

      check("sb_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad_n);
      $finish;
   end

endmodule
`default_nettype wire
